input_debounce: RTL and testbench

- Multi-channel synchroniser and debouncer for asynchronous board inputs before they reach the system GPIO input bus.
- Inputs covered: joystick, user switches, software-select switches, mikroBUS interrupt and microSD card-detect.
- Sits in the top level between the already-inverted switch signals and the GPIO input port. Runs in the system clock domain.
- Delivers clean levels plus single-cycle rise/fall event pulses per channel.

---
 rtl/input_debounce.sv | 125 ++++++++++++
 tb/tb_input_debounce.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
//
// Multi-channel synchroniser and debouncer for asynchronous board inputs
// (joystick, user switches, software-select switches, mikroBUS interrupt,
// microSD card-detect) ahead of the GPIO input bus. Each channel has its own
// two-flop synchroniser and its own stability counter, so the latency from a
// raw edge to the debounced edge is exact for every channel.
//
// Ports:
//   clk_sys_i   system clock
//   rst_sys_ni  asynchronous active-low reset
//   raw_i       [Width] asynchronous raw levels
//   bypass_i    1 = pass synchronised levels straight through (no filtering)
//   sw_o        [Width] debounced levels
//   rise_o      [Width] one-cycle pulse when sw_o[i] goes 0->1
//   fall_o      [Width] one-cycle pulse when sw_o[i] goes 1->0
//   changed_o   OR of all rise_o/fall_o bits (event strobe)
// -----------------------------------------------------------------------------
module input_debounce #(
  parameter int unsigned      Width        = 18,
  parameter int unsigned      StableCycles = 200000,
  parameter logic [Width-1:0] ResetValue   = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] raw_i,
  input  logic             bypass_i,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  // Counter must hold 0..StableCycles-1; the guard keeps widths legal while
  // the elaboration check below reports the bad parameter.
  localparam int unsigned CntW = (StableCycles == 0) ? 1 : $clog2(StableCycles + 1);
  localparam logic [CntW-1:0] CntLast =
      CntW'((StableCycles == 0) ? 0 : StableCycles - 1);

  if (StableCycles == 0) begin : g_param_check
    $error("input_debounce: StableCycles must be >= 1");
  end

  logic [Width-1:0] sync1_q;
  logic [Width-1:0] sync2_q;
  logic [Width-1:0] sw_q;
  logic [Width-1:0] sw_d;
  logic [Width-1:0] rise_q;
  logic [Width-1:0] rise_d;
  logic [Width-1:0] fall_q;
  logic [Width-1:0] fall_d;
  logic             changed_q;
  logic             changed_d;

  // ---------------------------------------------------------------------------
  // Per-channel stability filter
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < Width; gi++) begin : g_chan
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            bit_d;

    always_comb begin
      cnt_d = '0;
      bit_d = sw_q[gi];
      if (bypass_i) begin
        // Counter held at zero so filtering resumes from scratch on exit.
        bit_d = sync2_q[gi];
      end else if (sync2_q[gi] != sw_q[gi]) begin
        if (cnt_q == CntLast) begin
          // StableCycles consecutive differing cycles seen: accept the level
          // and restart the counter on the same edge.
          bit_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign sw_d[gi] = bit_d;
  end

  // Edges are computed from next vs current debounced level and registered,
  // so a pulse appears in the same cycle as the new sw_o value. sw_q doubles
  // as the "previous sw_o" register for this comparison, and since both share
  // ResetValue, reset release can never produce a pulse.
  always_comb begin
    rise_d    = sw_d & ~sw_q;
    fall_d    = ~sw_d & sw_q;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1_q   <= ResetValue;
      sync2_q   <= ResetValue;
      sw_q      <= ResetValue;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw_o      = sw_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_input_debounce
//
// Directed scenarios followed by a random phase, for Width=4, StableCycles=8,
// ResetValue=0. A reference model derives expected outputs from the rules:
// the filter sees raw_i two edges late; a channel flips when the last
// StableCycles filter samples all differ from the current level with bypass
// low; under bypass the level follows the filter sample directly.
// -----------------------------------------------------------------------------
module tb_input_debounce;

  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_i;
  logic       bypass_i;
  logic [3:0] sw_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic       changed_o;

  input_debounce #(
    .Width        (4),
    .StableCycles (S),
    .ResetValue   (4'b0000)
  ) dut (
    .clk_sys_i  (clk),
    .rst_sys_ni (rst_n),
    .raw_i      (raw_i),
    .bypass_i   (bypass_i),
    .sw_o       (sw_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .changed_o  (changed_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] raw_hist[$];
  logic [3:0] s_hist[$];
  bit         byp_hist[$];
  logic [3:0] sw_exp, rise_exp, fall_exp;
  logic       chg_exp;

  // Observed pulse counters for directed scenarios
  int rise_cnt[4];
  int fall_cnt[4];
  int chg_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    raw_hist = '{4'b0000, 4'b0000};
    s_hist.delete();
    byp_hist.delete();
    sw_exp   = 4'b0000;
    rise_exp = 4'b0000;
    fall_exp = 4'b0000;
    chg_exp  = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] s;
    logic [3:0] nsw;
    bit ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = raw_hist[0];
    raw_hist.push_back(raw_i);
    void'(raw_hist.pop_front());
    s_hist.push_back(s);
    byp_hist.push_back(bypass_i);
    if (s_hist.size() > S) begin
      void'(s_hist.pop_front());
      void'(byp_hist.pop_front());
    end
    nsw = sw_exp;
    for (int ch = 0; ch < 4; ch++) begin
      if (bypass_i) begin
        nsw[ch] = s[ch];
      end else if (s_hist.size() == S) begin
        ok = 1'b1;
        foreach (s_hist[k]) begin
          if (byp_hist[k] || (s_hist[k][ch] == sw_exp[ch])) ok = 1'b0;
        end
        if (ok) nsw[ch] = ~sw_exp[ch];
      end
    end
    rise_exp = nsw & ~sw_exp;
    fall_exp = ~nsw & sw_exp;
    chg_exp  = |(rise_exp | fall_exp);
    sw_exp   = nsw;
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < 4; ch++) begin
      rise_cnt[ch] = 0;
      fall_cnt[ch] = 0;
    end
    chg_cnt = 0;
  endtask

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("sw", {28'd0, sw_o}, {28'd0, sw_exp});
    chk("rise", {28'd0, rise_o}, {28'd0, rise_exp});
    chk("fall", {28'd0, fall_o}, {28'd0, fall_exp});
    chk("changed", {31'd0, changed_o}, {31'd0, chg_exp});
    for (int ch = 0; ch < 4; ch++) begin
      if (rise_o[ch] === 1'b1) rise_cnt[ch]++;
      if (fall_o[ch] === 1'b1) fall_cnt[ch]++;
    end
    if (changed_o === 1'b1) chg_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int low_seen;
    rst_n    = 1'b0;
    raw_i    = 4'b1111;
    bypass_i = 1'b0;
    model_reset();
    clear_counts();

    // Reset and idle: raw high throughout reset, released after 5 cycles.
    steps(5);
    chk("reset_sw", {28'd0, sw_o}, 32'h0);
    chk("reset_pulses", chg_cnt, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9) chk("rel_sw_early", {28'd0, sw_o}, 32'h0);
    end
    chk("rel_sw", {28'd0, sw_o}, 32'hF);
    chk("rel_rise", {28'd0, rise_o}, 32'hF);
    chk("rel_changed", {31'd0, changed_o}, 32'h1);
    step();
    chk("rel_rise_once", {28'd0, rise_o}, 32'h0);
    raw_i = 4'b0000;
    steps(12);

    // Glitch rejection: 7-cycle pulse on channel 0 must be filtered out.
    clear_counts();
    raw_i[0] = 1'b1;
    steps(7);
    raw_i[0] = 1'b0;
    steps(12);
    chk("glitch7_sw", {31'd0, sw_o[0]}, 32'h0);
    chk("glitch7_events", chg_cnt, 0);
    // 8-cycle pulse passes.
    clear_counts();
    raw_i[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 9) raw_i[0] = 1'b0;
      step();
      if (i == 9) chk("glitch8_early", {31'd0, sw_o[0]}, 32'h0);
    end
    chk("glitch8_sw", {31'd0, sw_o[0]}, 32'h1);
    steps(12);
    chk("glitch8_rise_cnt", rise_cnt[0], 1);

    // Bouncing release on channel 2.
    raw_i = 4'b0100;
    steps(12);
    clear_counts();
    low_seen = 0;
    for (int j = 0; j < 10; j++) begin
      raw_i[2] = (j % 2 == 1);
      for (int k = 0; k < 3; k++) begin
        step();
        if (sw_o[2] !== 1'b1) low_seen++;
      end
    end
    chk("bounce_hold", low_seen, 0);
    raw_i[2] = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (sw_o[2] !== 1'b0 && n < 30);
    chk("bounce_latency", n, 10);
    steps(4);
    chk("bounce_fall_cnt", fall_cnt[2], 1);

    // Simultaneous channels.
    clear_counts();
    raw_i = 4'b0101;
    steps(10);
    chk("simul_sw", {28'd0, sw_o}, 32'h5);
    chk("simul_rise", {28'd0, rise_o}, 32'h5);
    step();
    chk("simul_rise_off", {28'd0, rise_o}, 32'h0);
    chk("simul_chg_cnt", chg_cnt, 1);
    raw_i = 4'b0000;
    steps(12);

    // Bypass: a single-cycle raw pulse appears 3 cycles later.
    clear_counts();
    bypass_i = 1'b1;
    step();
    raw_i[1] = 1'b1;
    step();
    raw_i[1] = 1'b0;
    step();
    step();
    chk("byp_sw_hi", {31'd0, sw_o[1]}, 32'h1);
    step();
    chk("byp_sw_lo", {31'd0, sw_o[1]}, 32'h0);
    steps(3);
    chk("byp_rise_cnt", rise_cnt[1], 1);
    chk("byp_fall_cnt", fall_cnt[1], 1);
    // Count of 5 in progress, bypass entry takes the level, exit recounts from 0.
    bypass_i = 1'b0;
    raw_i[1] = 1'b1;
    steps(7);
    chk("cnt5_sw", {31'd0, sw_o[1]}, 32'h0);
    bypass_i = 1'b1;
    step();
    chk("byp_take", {31'd0, sw_o[1]}, 32'h1);
    bypass_i = 1'b0;
    raw_i[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9) chk("resume_early", {31'd0, sw_o[1]}, 32'h1);
    end
    chk("resume_sw", {31'd0, sw_o[1]}, 32'h0);

    // Reset mid-count on channel 3 while channel 0 is high.
    raw_i = 4'b0001;
    steps(12);
    raw_i = 4'b1001;
    steps(7);
    chk("midcnt_sw", {28'd0, sw_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_sw", {28'd0, sw_o}, 32'h0);
    steps(3);
    clear_counts();
    rst_n = 1'b1;
    steps(10);
    chk("rst_rel_sw", {28'd0, sw_o}, 32'h9);
    chk("rst_rel_rise", {28'd0, rise_o}, 32'h9);
    steps(4);
    chk("rst_rel_rise_cnt", rise_cnt[3], 1);

    // Random phase: sporadic bit flips and short bypass bursts.
    for (int i = 0; i < 600; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(0, 5) == 0) raw_i[ch] = ~raw_i[ch];
      end
      if (bypass_i) begin
        if ($urandom_range(0, 3) == 0) bypass_i = 1'b0;
      end else if ($urandom_range(0, 40) == 0) begin
        bypass_i = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
